// File: rtl/imm_encoder.sv
// Immediate scatter encoder (inverse of the RISC-V immediate sign-extender) with a
// registered output and one-entry skid buffer. Optional counters: define IMM_ENC_STATS_EN.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      base_inst,
  input  logic [31:0]      imm,
  input  logic [2:0]       enc_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst,
  output logic             err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    OP_I = 3'b000,
    OP_S = 3'b001,
    OP_B = 3'b010,
    OP_U = 3'b011,
    OP_J = 3'b100
  } enc_op_e;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } result_t;

  // Sign-extension fit tests: the bits above the field's sign bit must all match it.
  logic fits_12, fits_13, fits_21;
  assign fits_12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits_13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits_21 = (imm[31:20] == '0) || (imm[31:20] == '1);

  result_t enc_res;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    enc_res.inst = base_inst;
    enc_res.err  = 1'b1;
    case (enc_op)
      OP_I: begin
        enc_res.inst = {imm[11:0], base_inst[19:0]};
        enc_res.err  = ~fits_12;
      end
      OP_S: begin
        enc_res.inst = {imm[11:5], base_inst[24:12], imm[4:0], base_inst[6:0]};
        enc_res.err  = ~fits_12;
      end
      OP_B: begin
        enc_res.inst = {imm[12], imm[10:5], base_inst[24:12], imm[4:1], imm[11],
                        base_inst[6:0]};
        enc_res.err  = ~fits_13 | imm[0];
      end
      OP_U: begin
        enc_res.inst = {imm[31:12], base_inst[11:0]};
        enc_res.err  = (imm[11:0] != 12'd0);
      end
      OP_J: begin
        enc_res.inst = {imm[20], imm[10:1], imm[11], imm[19:12], base_inst[11:0]};
        enc_res.err  = ~fits_21 | imm[0];
      end
      default: begin
        enc_res.inst = base_inst;
        enc_res.err  = 1'b1;
      end
    endcase
  end

  result_t main_q, main_d, skid_q, skid_d;
  logic    main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic    accept, drain;

  assign in_ready  = ~skid_vld_q;
  assign out_valid = main_vld_q;
  assign inst      = main_q.inst;
  assign err       = main_q.err;
  assign accept    = in_valid & in_ready;
  assign drain     = main_vld_q & out_ready;

  // The skid entry can only be full while in_ready is low, so accept and a full skid
  // never coincide; ordering follows from the skid always feeding main first.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (drain) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d = enc_res;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (main_vld_q) begin
        skid_d     = enc_res;
        skid_vld_d = 1'b1;
      end else begin
        main_d     = enc_res;
        main_vld_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

`ifdef IMM_ENC_STATS_EN
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (drain) begin
      if (enc_cnt_q != '1) enc_cnt_d = enc_cnt_q + 1'b1;
      if (main_q.err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign enc_cnt = enc_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign enc_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule
